// File: rtl/store_addr_unit.sv
// Multi-lane store address generation: per-lane effective address, byte mask, aligned data
// and misalignment flag, buffered in a kill-aware FIFO with valid/ready handoff to the store queue.
module store_addr_unit #(
   parameter int NUM_LANES  = 2,
   parameter int XLEN       = 32,
   parameter int DATA_BYTES = 4,
   parameter int SQ_SZ      = 8,
   parameter int PREG_W     = 6,
   parameter int DEPTH      = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_LANES-1:0]             in_valid,
   output logic [NUM_LANES-1:0]             in_ready,
   input  logic [NUM_LANES*XLEN-1:0]        in_base,
   input  logic [NUM_LANES*XLEN-1:0]        in_imm,
   input  logic [NUM_LANES*XLEN-1:0]        in_data,
   input  logic [NUM_LANES*3-1:0]           in_func,
   input  logic [NUM_LANES*SQ_SZ-1:0]       in_sq_mask,
   input  logic [NUM_LANES*PREG_W-1:0]      in_dest,
   input  logic [SQ_SZ-1:0]                 squash_mask,
   output logic [NUM_LANES-1:0]             out_valid,
   input  logic [NUM_LANES-1:0]             out_ready,
   output logic [NUM_LANES*XLEN-1:0]        out_addr,
   output logic [NUM_LANES*DATA_BYTES*8-1:0] out_data,
   output logic [NUM_LANES*DATA_BYTES-1:0]  out_byte_mask,
   output logic [NUM_LANES-1:0]             out_misaligned,
   output logic [NUM_LANES*PREG_W-1:0]      out_dest,
   output logic [NUM_LANES*SQ_SZ-1:0]       out_sq_mask,
   output logic [SQ_SZ-1:0]                 resolving_sq_mask
);
   localparam int DW    = DATA_BYTES * 8;
   localparam int OFF_W = $clog2(DATA_BYTES);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0]       addr;
      logic [DW-1:0]         data;
      logic [DATA_BYTES-1:0] bmask;
      logic                  mis;
      logic [PREG_W-1:0]     dest;
      logic [SQ_SZ-1:0]      sq;
   } entry_t;

   logic [NUM_LANES-1:0] w_hand_off;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      entry_t                w_new;
      entry_t                r_mem [DEPTH];
      logic [DEPTH-1:0]      r_kill;
      logic [PTR_W-1:0]      r_rd;
      logic [PTR_W-1:0]      r_wr;
      logic [CNT_W-1:0]      r_count;
      logic [XLEN-1:0]       w_addr;
      logic [1:0]            w_size;
      logic [OFF_W-1:0]      w_off;
      logic [DATA_BYTES-1:0] w_size_mask;
      logic [DW+XLEN-1:0]    w_data_wide;
      logic                  w_unused_func;
      logic                  w_push;
      logic                  w_pop;
      logic                  w_present;
      logic                  w_head_kill;
      logic                  w_out_valid;

      assign w_addr        = in_base[l*XLEN +: XLEN] + in_imm[l*XLEN +: XLEN];
      assign w_size        = in_func[l*3 +: 2];
      assign w_unused_func = in_func[l*3+2];
      assign w_off         = w_addr[OFF_W-1:0];
      assign w_data_wide   = {{DW{1'b0}}, in_data[l*XLEN +: XLEN]} << {w_off, 3'b000};

      always_comb begin
         // NOTE: defaults first, so no path through the case can leave a latch behind.
         w_size_mask = '0;
         w_new       = '0;
         case (w_size)
            2'd0: w_size_mask = DATA_BYTES'(1);
            2'd1: begin
               w_size_mask = DATA_BYTES'(3);
               w_new.mis   = w_addr[0];
            end
            2'd2: begin
               w_size_mask = DATA_BYTES'(15);
               w_new.mis   = |w_addr[1:0];
            end
            default: w_new.mis = 1'b1;
         endcase
         w_new.addr  = w_addr;
         w_new.data  = w_data_wide[DW-1:0];
         w_new.bmask = w_size_mask << w_off;
         w_new.dest  = in_dest[l*PREG_W +: PREG_W];
         w_new.sq    = in_sq_mask[l*SQ_SZ +: SQ_SZ];
      end

      assign w_present   = (r_count != '0);
      assign w_head_kill = w_present & r_kill[r_rd];
      assign w_out_valid = w_present & ~r_kill[r_rd] & ~reset;
      assign in_ready[l] = (r_count < CNT_W'(DEPTH));
      assign w_push      = in_valid[l] & in_ready[l];
      assign w_pop       = w_head_kill | (w_out_valid & out_ready[l]);

      // NOTE: non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_kill  <= '0;
         end else begin
            // A slot being written takes the squash verdict of the incoming store.
            for (int j = 0; j < DEPTH; j++) begin
               if (w_push && (r_wr == PTR_W'(j)))
                  r_kill[j] <= |(w_new.sq & squash_mask);
               else if (|(r_mem[j].sq & squash_mask))
                  r_kill[j] <= 1'b1;
            end
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end

      // NOTE: payload storage has no reset; count and kill bits alone decide what is live.
      always_ff @(posedge clock) begin
         if (w_push) r_mem[r_wr] <= w_new;
      end

      assign out_valid[l]                          = w_out_valid;
      assign out_addr[l*XLEN +: XLEN]              = r_mem[r_rd].addr;
      assign out_data[l*DW +: DW]                  = r_mem[r_rd].data;
      assign out_byte_mask[l*DATA_BYTES +: DATA_BYTES] = r_mem[r_rd].bmask;
      assign out_misaligned[l]                     = r_mem[r_rd].mis;
      assign out_dest[l*PREG_W +: PREG_W]          = r_mem[r_rd].dest;
      assign out_sq_mask[l*SQ_SZ +: SQ_SZ]         = r_mem[r_rd].sq;
      assign w_hand_off[l]                         = w_out_valid & out_ready[l];
   end

   always_comb begin
      resolving_sq_mask = '0;
      for (int l = 0; l < NUM_LANES; l++)
         if (w_hand_off[l]) resolving_sq_mask = resolving_sq_mask | out_sq_mask[l*SQ_SZ +: SQ_SZ];
   end
endmodule

// File: tb/tb_store_addr_unit.sv
// Self-checking bench for store_addr_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_store_addr_unit;
   localparam int NUM_LANES  = 2;
   localparam int XLEN       = 32;
   localparam int DATA_BYTES = 4;
   localparam int SQ_SZ      = 8;
   localparam int PREG_W     = 6;
   localparam int DEPTH      = 2;
   localparam int DW         = DATA_BYTES * 8;

   logic                              clock = 1'b0;
   logic                              reset;
   logic [NUM_LANES-1:0]              in_valid;
   logic [NUM_LANES-1:0]              in_ready;
   logic [NUM_LANES*XLEN-1:0]         in_base;
   logic [NUM_LANES*XLEN-1:0]         in_imm;
   logic [NUM_LANES*XLEN-1:0]         in_data;
   logic [NUM_LANES*3-1:0]            in_func;
   logic [NUM_LANES*SQ_SZ-1:0]        in_sq_mask;
   logic [NUM_LANES*PREG_W-1:0]       in_dest;
   logic [SQ_SZ-1:0]                  squash_mask;
   logic [NUM_LANES-1:0]              out_valid;
   logic [NUM_LANES-1:0]              out_ready;
   logic [NUM_LANES*XLEN-1:0]         out_addr;
   logic [NUM_LANES*DW-1:0]           out_data;
   logic [NUM_LANES*DATA_BYTES-1:0]   out_byte_mask;
   logic [NUM_LANES-1:0]              out_misaligned;
   logic [NUM_LANES*PREG_W-1:0]       out_dest;
   logic [NUM_LANES*SQ_SZ-1:0]        out_sq_mask;
   logic [SQ_SZ-1:0]                  resolving_sq_mask;

   store_addr_unit #(
      .NUM_LANES(NUM_LANES), .XLEN(XLEN), .DATA_BYTES(DATA_BYTES),
      .SQ_SZ(SQ_SZ), .PREG_W(PREG_W), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_imm(in_imm),
      .in_data(in_data), .in_func(in_func), .in_sq_mask(in_sq_mask), .in_dest(in_dest),
      .squash_mask(squash_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_byte_mask(out_byte_mask),
      .out_misaligned(out_misaligned), .out_dest(out_dest), .out_sq_mask(out_sq_mask),
      .resolving_sq_mask(resolving_sq_mask)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_pass  = 0;
   bit model_on = 1'b0;

   typedef struct {
      logic [XLEN-1:0]       addr;
      logic [DW-1:0]         data;
      logic [DATA_BYTES-1:0] mask;
      logic                  mis;
      logic [PREG_W-1:0]     dest;
      logic [SQ_SZ-1:0]      sq;
      bit                    killed;
   } ment_t;

   typedef struct {
      logic [31:0] base;
      logic [31:0] imm;
      logic [31:0] data;
      logic [2:0]  func;
      logic [31:0] e_addr;
      logic [3:0]  e_mask;
      logic [31:0] e_data;
      logic        e_mis;
   } vec_t;

   ment_t mq [NUM_LANES][$];
   vec_t  vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Store semantics written as plain arithmetic on addresses and byte counts.
   function automatic ment_t ref_calc(input logic [XLEN-1:0] base, input logic [XLEN-1:0] imm,
                                      input logic [XLEN-1:0] data, input logic [2:0] func);
      ment_t e;
      longint unsigned a, off, sz, m, d;
      a   = (64'(base) + 64'(imm)) % (64'd1 << XLEN);
      off = a % DATA_BYTES;
      case (func[1:0])
         2'd0:    sz = 1;
         2'd1:    sz = 3;
         2'd2:    sz = 15;
         default: sz = 0;
      endcase
      m = (sz << off) % (64'd1 << DATA_BYTES);
      d = (64'(data) << (off * 8)) % (64'd1 << DW);
      e.addr   = a[XLEN-1:0];
      e.data   = d[DW-1:0];
      e.mask   = m[DATA_BYTES-1:0];
      e.mis    = ((func[1:0] == 2'd1) && (a % 2 != 0)) || ((func[1:0] == 2'd2) && (a % 4 != 0)) ||
                 (func[1:0] == 2'd3);
      e.dest   = '0;
      e.sq     = '0;
      e.killed = 1'b0;
      return e;
   endfunction

   task automatic model_check();
      logic [SQ_SZ-1:0] exp_res;
      exp_res = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bit exp_v;
         exp_v = (mq[l].size() > 0) && !mq[l][0].killed && !reset;
         check($sformatf("m_in_ready%0d", l), in_ready[l], mq[l].size() < DEPTH);
         check($sformatf("m_out_valid%0d", l), out_valid[l], exp_v);
         if (exp_v) begin
            check($sformatf("m_addr%0d", l), out_addr[l*XLEN +: XLEN], mq[l][0].addr);
            check($sformatf("m_data%0d", l), out_data[l*DW +: DW], mq[l][0].data);
            check($sformatf("m_mask%0d", l), out_byte_mask[l*DATA_BYTES +: DATA_BYTES], mq[l][0].mask);
            check($sformatf("m_mis%0d", l), out_misaligned[l], mq[l][0].mis);
            check($sformatf("m_dest%0d", l), out_dest[l*PREG_W +: PREG_W], mq[l][0].dest);
            check($sformatf("m_sq%0d", l), out_sq_mask[l*SQ_SZ +: SQ_SZ], mq[l][0].sq);
            if (out_ready[l]) exp_res = exp_res | mq[l][0].sq;
         end
      end
      check("m_resolving", resolving_sq_mask, exp_res);
   endtask

   task automatic model_update();
      if (reset) begin
         for (int l = 0; l < NUM_LANES; l++) mq[l].delete();
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            bit    push, pop;
            ment_t e;
            push = in_valid[l] && (mq[l].size() < DEPTH);
            pop  = (mq[l].size() > 0) && (mq[l][0].killed || out_ready[l]);
            e = ref_calc(in_base[l*XLEN +: XLEN], in_imm[l*XLEN +: XLEN],
                         in_data[l*XLEN +: XLEN], in_func[l*3 +: 3]);
            e.dest   = in_dest[l*PREG_W +: PREG_W];
            e.sq     = in_sq_mask[l*SQ_SZ +: SQ_SZ];
            e.killed = |(e.sq & squash_mask);
            if (pop) void'(mq[l].pop_front());
            for (int k = 0; k < mq[l].size(); k++)
               if (|(mq[l][k].sq & squash_mask)) mq[l][k].killed = 1'b1;
            if (push) mq[l].push_back(e);
         end
      end
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic cycle();
      #2;
      if (model_on) model_check();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int l, input bit v, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] data, input logic [2:0] func,
                        input logic [7:0] sq, input logic [5:0] dest);
      in_valid[l]                    = v;
      in_base[l*XLEN +: XLEN]        = base;
      in_imm[l*XLEN +: XLEN]         = imm;
      in_data[l*XLEN +: XLEN]        = data;
      in_func[l*3 +: 3]              = func;
      in_sq_mask[l*SQ_SZ +: SQ_SZ]   = sq;
      in_dest[l*PREG_W +: PREG_W]    = dest;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h1000, 32'h6,        32'hABCD,     3'd1, 32'h1006,     4'b1100, 32'hABCD0000, 1'b0};
      vecs[1] = '{32'h1001, 32'h0,        32'h11223344, 3'd2, 32'h1001,     4'b1110, 32'h22334400, 1'b1};
      vecs[2] = '{32'h0,    32'hFFFFFFFF, 32'h5A,       3'd0, 32'hFFFFFFFF, 4'b1000, 32'h5A000000, 1'b0};
      vecs[3] = '{32'h2000, 32'h4,        32'hDEADBEEF, 3'd2, 32'h2004,     4'b1111, 32'hDEADBEEF, 1'b0};
      vecs[4] = '{32'h10,   32'h3,        32'h1234,     3'd1, 32'h13,       4'b1000, 32'h34000000, 1'b1};
      vecs[5] = '{32'h100,  32'h2,        32'hFF,       3'd3, 32'h102,      4'b0000, 32'h00FF0000, 1'b1};
      vecs[6] = '{32'h7,    32'hFFFFFFFA, 32'h77,       3'd0, 32'h1,        4'b0010, 32'h00007700, 1'b0};

      reset = 1'b1; in_valid = '0; in_base = '0; in_imm = '0; in_data = '0; in_func = '0;
      in_sq_mask = '0; in_dest = '0; squash_mask = '0; out_ready = '0;
      @(posedge clock); #1;
      cycle(); cycle();
      reset = 1'b0; #1;
      check("rst_out_valid", out_valid, 2'b00);
      check("rst_in_ready", in_ready, 2'b11);
      check("rst_resolving", resolving_sq_mask, 8'h00);
      model_on = 1'b1;

      // Directed vectors on lane 0, one store at a time.
      out_ready = 2'b11;
      for (int i = 0; i < 7; i++) begin
         logic [7:0] sq;
         sq = 8'b1 << (i % 8);
         drive(0, 1'b1, vecs[i].base, vecs[i].imm, vecs[i].data, vecs[i].func, sq, 6'(i));
         cycle();
         in_valid = '0; #1;
         check($sformatf("vec%0d_valid", i), out_valid[0], 1'b1);
         check($sformatf("vec%0d_addr", i), out_addr[31:0], vecs[i].e_addr);
         check($sformatf("vec%0d_mask", i), out_byte_mask[3:0], vecs[i].e_mask);
         check($sformatf("vec%0d_data", i), out_data[31:0], vecs[i].e_data);
         check($sformatf("vec%0d_mis", i), out_misaligned[0], vecs[i].e_mis);
         check($sformatf("vec%0d_dest", i), out_dest[5:0], 6'(i));
         check($sformatf("vec%0d_resolve", i), resolving_sq_mask, sq);
         cycle();
      end

      // Backpressure on lane 1: third store waits for a free slot, order preserved.
      out_ready = 2'b00;
      drive(1, 1'b1, 32'h100, 32'h0, 32'hA1, 3'd2, 8'h01, 6'd1); cycle();
      drive(1, 1'b1, 32'h200, 32'h0, 32'hA2, 3'd2, 8'h02, 6'd2); cycle();
      #1; check("bp_full_ready", in_ready[1], 1'b0);
      drive(1, 1'b1, 32'h300, 32'h0, 32'hA3, 3'd2, 8'h04, 6'd3);
      for (int k = 0; k < 2; k++) begin
         #1;
         check("bp_hold_valid", out_valid[1], 1'b1);
         check("bp_hold_addr", out_addr[63:32], 32'h100);
         cycle();
      end
      out_ready = 2'b10; #1;
      check("bp_first_addr", out_addr[63:32], 32'h100);
      check("bp_no_comb_ready", in_ready[1], 1'b0);
      check("bp_first_resolve", resolving_sq_mask, 8'h01);
      cycle();
      #1;
      check("bp_second_addr", out_addr[63:32], 32'h200);
      check("bp_slot_free", in_ready[1], 1'b1);
      cycle();
      in_valid = '0; #1;
      check("bp_third_addr", out_addr[63:32], 32'h300);
      check("bp_third_resolve", resolving_sq_mask, 8'h04);
      cycle();
      #1; check("bp_drained", out_valid[1], 1'b0);

      // Squash of the head entry on lane 0.
      out_ready = 2'b00;
      drive(0, 1'b1, 32'h400, 32'h0, 32'h11, 3'd2, 8'b0001, 6'd10); cycle();
      drive(0, 1'b1, 32'h500, 32'h0, 32'h22, 3'd2, 8'b0010, 6'd11); cycle();
      in_valid = '0; squash_mask = 8'b0001; cycle();
      squash_mask = '0; out_ready = 2'b01; #1;
      check("sq_head_killed", out_valid[0], 1'b0);
      check("sq_no_resolve", resolving_sq_mask, 8'h00);
      cycle();
      #1;
      check("sq_next_valid", out_valid[0], 1'b1);
      check("sq_next_addr", out_addr[31:0], 32'h500);
      check("sq_next_resolve", resolving_sq_mask, 8'b0010);
      cycle();
      #1; check("sq_drained", out_valid[0], 1'b0);

      // Both lanes hand off together.
      out_ready = 2'b00;
      drive(0, 1'b1, 32'h600, 32'h0, 32'h33, 3'd2, 8'b0100, 6'd20);
      drive(1, 1'b1, 32'h700, 32'h0, 32'h44, 3'd2, 8'b1000, 6'd21);
      cycle();
      in_valid = '0; out_ready = 2'b11; #1;
      check("dual_resolve", resolving_sq_mask, 8'b1100);
      cycle();

      // Streaming push+pop every cycle; pointers wrap several times.
      out_ready = 2'b01;
      for (int k = 0; k < 10; k++) begin
         drive(0, 1'b1, 32'(32'h800 + k * 16), 32'h0, 32'(k), 3'd2, 8'b1 << (k % 8), 6'(k));
         #1;
         check("stream_ready", in_ready[0], 1'b1);
         if (k > 0) begin
            check("stream_valid", out_valid[0], 1'b1);
            check("stream_addr", out_addr[31:0], 32'(32'h800 + (k - 1) * 16));
         end
         cycle();
      end
      in_valid = '0; #1;
      check("stream_last_addr", out_addr[31:0], 32'h890);
      cycle();

      // Reset with both FIFOs full.
      out_ready = 2'b00;
      drive(0, 1'b1, 32'hA00, 32'h0, 32'h1, 3'd2, 8'h01, 6'd1);
      drive(1, 1'b1, 32'hB00, 32'h0, 32'h2, 3'd2, 8'h02, 6'd2);
      cycle();
      drive(0, 1'b1, 32'hA04, 32'h0, 32'h3, 3'd2, 8'h04, 6'd3);
      drive(1, 1'b1, 32'hB04, 32'h0, 32'h4, 3'd2, 8'h08, 6'd4);
      cycle();
      in_valid = '0; #1;
      check("full_ready", in_ready, 2'b00);
      out_ready = 2'b11; reset = 1'b1; #1;
      check("rst_mid_valid", out_valid, 2'b00);
      check("rst_mid_resolve", resolving_sq_mask, 8'h00);
      cycle();
      reset = 1'b0; #1;
      check("rst_after_valid", out_valid, 2'b00);
      check("rst_after_ready", in_ready, 2'b11);
      check("rst_after_resolve", resolving_sq_mask, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cycle();
         #1; check("rst_no_stale", out_valid, 2'b00);
      end

      // Randomized traffic against the reference model.
      for (int c = 0; c < 2000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         for (int l = 0; l < NUM_LANES; l++)
            drive(l, $urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)),
                  $urandom, 3'($urandom_range(0, 7)), 8'b1 << $urandom_range(0, 7), 6'($urandom));
         out_ready   = 2'($urandom);
         squash_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         cycle();
      end
      reset = 1'b0; in_valid = '0; squash_mask = '0; out_ready = 2'b11;
      for (int k = 0; k < 4; k++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/store_addr_unit.md
Name: store_addr_unit

Overview:
- Multi-lane store address generation unit between issue and the store queue.
- Each lane computes the effective address, shifted store data, byte mask and a misalignment flag for one store per cycle.
- Results are buffered in a per-lane FIFO with valid/ready handshake toward the store queue, so the queue can backpressure.
- In-flight entries are killed by an SQ-mask squash.

Parameters:
NUM_LANES, 2, independent store lanes
XLEN, 32, address/data width
DATA_BYTES, 4, bytes per store-queue data word (power of 2, ≥4)
SQ_SZ, 8, store queue entries; width of one-hot sq_mask
PREG_W, 6, physical register tag width
DEPTH, 2, entries per lane FIFO (power of 2, ≥2)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  NUM_LANES  per-lane issue valid
in_ready  out  NUM_LANES  per-lane accept; in_ready[i] = (count_i < DEPTH), registered count only
in_base  in  NUM_LANES*XLEN  rs1 value per lane
in_imm  in  NUM_LANES*XLEN  sign-extended store immediate
in_data  in  NUM_LANES*XLEN  rs2 value (low bytes significant)
in_func  in  NUM_LANES*3  store funct3; [1:0]: 0 byte, 1 half, 2 word, 3 reserved
in_sq_mask  in  NUM_LANES*SQ_SZ  one-hot SQ slot of the store
in_dest  in  NUM_LANES*PREG_W  tag forwarded to store queue
squash_mask  in  SQ_SZ  slots being squashed this cycle
out_valid  out  NUM_LANES  head entry valid and not killed
out_ready  in  NUM_LANES  store queue accepts lane head
out_addr  out  NUM_LANES*XLEN  effective address
out_data  out  NUM_LANES*DATA_BYTES*8  data shifted to byte offset
out_byte_mask  out  NUM_LANES*DATA_BYTES  bytes written
out_misaligned  out  NUM_LANES  alignment fault
out_dest  out  NUM_LANES*PREG_W  forwarded tag
out_sq_mask  out  NUM_LANES*SQ_SZ  slot of head entry
resolving_sq_mask  out  SQ_SZ  OR of out_sq_mask over lanes with out_valid&out_ready this cycle

Behaviour:
- Compute on push (combinational on inputs, result stored in FIFO): addr = in_base + in_imm mod 2^XLEN; off = addr[log2(DATA_BYTES)-1:0]; size_mask = 1/3/15 for byte/half/word; byte_mask = (size_mask << off) truncated to DATA_BYTES bits; data = zero-extend(in_data) << (off*8), truncated.
- misaligned = 1 when half with addr[0]=1, word with addr[1:0]≠0, or func reserved. Reserved func forces byte_mask = 0. Misaligned entries are still delivered; the store queue handles the fault.
- Push when in_valid & in_ready. Pop when the head is killed, or out_valid & out_ready. Push and pop may occur in the same cycle; count is unchanged.
- At count==DEPTH, in_ready=0 even if a pop occurs that cycle; no combinational ready path.
- Latency: an entry pushed in cycle N is visible at the head in N+1 at the earliest.
- Rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH. Lanes are fully independent; within a lane, order is preserved.
- Squash kills every stored entry with (sq_mask & squash_mask)≠0 by setting its kill bit at the clock edge. An input pushed in the same cycle and matching squash_mask is stored already killed.
- A killed head has out_valid=0 and is popped automatically, one per cycle per lane, without regard to out_ready.
- out_valid = head present & ~kill. Other outputs show head contents and are don't-care when out_valid=0.
- resolving_sq_mask = 0 when no lane hands off.
- Reset: all counts and pointers 0, all kill bits cleared, out_valid=0, in_ready all 1, resolving_sq_mask=0. Reset mid-operation discards all entries with no handoff in that cycle.
- Outputs are stable while out_valid=1 & out_ready=0.

Test Plan:
- Lane0: base=0x1000, imm=0x6, data=0xABCD, func=half, out_ready=1 → next cycle addr=0x1006, byte_mask=0b1100, data=0xABCD0000, misaligned=0, resolving_sq_mask=lane sq_mask.
- Word store base=0x1001, imm=0 → byte_mask 0b1110 truncated, misaligned=1. Byte store imm=-1 (0xFFFFFFFF) from base 0 → addr=0xFFFFFFFF, mask 0b1000.
- out_ready=0, push 3 stores on lane1 with DEPTH=2 → in_ready drops after 2nd push. Outputs hold 1st entry. Release out_ready → all delivered in order, third accepted after a slot frees.
- Fill lane0 with slots 0b0001 and 0b0010, pulse squash_mask=0b0001 → first is dropped silently, second is delivered next, and resolving_sq_mask never contains 0b0001.
- Both lanes hand off in the same cycle with slots 0b0100 and 0b1000 → resolving_sq_mask=0b1100. Push and pop in the same cycle keep count constant; pointers wrap correctly over 10 ops.
- Assert reset with both FIFOs full → next cycle out_valid=0, in_ready=all 1, no stale entry appears afterward.
